// File: rtl/riscv_consts.sv
// Shared RV32I encodings used by the writeback stage.
package riscv_consts;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    FUNCT3_LB  = 3'b000,
    FUNCT3_LH  = 3'b001,
    FUNCT3_LW  = 3'b010,
    FUNCT3_LBU = 3'b100,
    FUNCT3_LHU = 3'b101
  } funct3_e;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational load alignment: picks byte/half/word by offset, extends, flags misalignment.
module load_extract
  import riscv_consts::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = word[7:0];
    case (off)
      2'd0:    ld_byte = word[7:0];
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = off[1] ? word[31:16] : word[15:0];
  end

  // Unlisted funct3 codes behave exactly like LW, including the alignment rule.
  always_comb begin
    data       = word;
    misaligned = (off != 2'd0);
    case (funct3)
      FUNCT3_LB: begin
        data       = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        misaligned = 1'b0;
      end
      FUNCT3_LBU: begin
        data       = {{(XLEN-8){1'b0}}, ld_byte};
        misaligned = 1'b0;
      end
      FUNCT3_LH: begin
        data       = {{(XLEN-16){ld_half[15]}}, ld_half};
        misaligned = off[0];
      end
      FUNCT3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, ld_half};
        misaligned = off[0];
      end
      default: begin
        data       = word;
        misaligned = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: WB pipeline register, load data hold buffer,
// register-file write port, retired-instruction counter and sticky misalign flag.
module wb_stage
  import riscv_consts::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic [1:0]       ex_wb_sel,
  input  logic [XLEN-1:0]  ex_alu_out,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret,
  output logic             load_misalign
);

  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_we_q, reg_we_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]  alu_out_q, alu_out_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             hold_vld_q, hold_vld_d;
  logic [XLEN-1:0]  hold_word_q, hold_word_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             misalign_q, misalign_d;

  logic             is_mem;
  logic             retire;
  logic             ld_misaligned;
  logic [XLEN-1:0]  ld_word;
  logic [XLEN-1:0]  ld_data;

  assign is_mem  = (wb_sel_q == WB_SEL_MEM);
  assign retire  = valid_q & ~stall & ~flush;
  // dmem_rdata is only good in the first WB cycle; later stalled cycles use the captured copy.
  assign ld_word = hold_vld_q ? hold_word_q : dmem_rdata;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .word       (ld_word),
    .funct3     (funct3_q),
    .off        (alu_out_q[1:0]),
    .data       (ld_data),
    .misaligned (ld_misaligned)
  );

  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    reg_we_d    = reg_we_q;
    wb_sel_d    = wb_sel_q;
    alu_out_d   = alu_out_q;
    pc_d        = pc_q;
    funct3_d    = funct3_q;
    hold_vld_d  = hold_vld_q;
    hold_word_d = hold_word_q;
    if (flush) begin
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
    end else if (!stall) begin
      valid_d    = ex_valid;
      rd_d       = ex_rd;
      reg_we_d   = ex_reg_we;
      wb_sel_d   = ex_wb_sel;
      alu_out_d  = ex_alu_out;
      pc_d       = ex_pc;
      funct3_d   = ex_funct3;
      hold_vld_d = 1'b0;
    end else if (valid_q && is_mem && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_word_d = dmem_rdata;
    end
    instret_d  = instret_q + CNT_W'(retire);
    misalign_d = misalign_q | (valid_q & is_mem & ld_misaligned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      reg_we_q    <= 1'b0;
      wb_sel_q    <= '0;
      alu_out_q   <= '0;
      pc_q        <= '0;
      funct3_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_word_q <= '0;
      instret_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      reg_we_q    <= reg_we_d;
      wb_sel_q    <= wb_sel_d;
      alu_out_q   <= alu_out_d;
      pc_q        <= pc_d;
      funct3_q    <= funct3_d;
      hold_vld_q  <= hold_vld_d;
      hold_word_q <= hold_word_d;
      instret_q   <= instret_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    case (wb_sel_q)
      WB_SEL_MEM: rf_wd = ld_data;
      WB_SEL_PC4: rf_wd = pc_q + XLEN'(4);
      default:    rf_wd = alu_out_q;
    endcase
  end

  assign rf_we         = valid_q & reg_we_q & (rd_q != 5'd0) & ~(is_mem & ld_misaligned);
  assign rf_wa         = rd_q;
  assign fwd_valid     = rf_we;
  assign wb_valid      = valid_q;
  assign instret       = instret_q;
  assign load_misalign = misalign_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_reg_we;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_out, ex_pc, dmem_rdata;
  logic [2:0]  ex_funct3;
  logic        rf_we, fwd_valid, wb_valid, load_misalign;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, instret;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instret = '0;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_wb_sel(ex_wb_sel),
    .ex_alu_out(ex_alu_out), .ex_pc(ex_pc), .ex_funct3(ex_funct3), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .fwd_valid(fwd_valid), .wb_valid(wb_valid),
    .instret(instret), .load_misalign(load_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    ex_valid = 1'b1; ex_rd = rd; ex_reg_we = we; ex_wb_sel = sel;
    ex_alu_out = alu; ex_pc = pc; ex_funct3 = f3;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_rd = 5'd0; ex_reg_we = 1'b0; ex_wb_sel = 2'd0;
    ex_alu_out = '0; ex_pc = '0; ex_funct3 = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem_rdata = '0; idle();
    step(); step();
    rst = 1'b0;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd got=%b exp=0", fwd_valid); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (rf_wa !== 5'd0) begin failures++; $display("FAIL reset_rf_wa got=%0d exp=0", rf_wa); end
    checks++; if (rf_wd !== 32'h0) begin failures++; $display("FAIL reset_rf_wd got=%h exp=0", rf_wd); end
    checks++; if (instret !== 32'h0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if (load_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", load_misalign); end
  endtask

  task automatic test_alu();
    issue(5'd5, 1'b1, 2'd0, 32'h1234, 32'h100, 3'd0);
    step(); idle();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_rf_we got=%b exp=1", rf_we); end
    checks++; if (fwd_valid !== 1'b1) begin failures++; $display("FAIL alu_fwd got=%b exp=1", fwd_valid); end
    checks++; if (rf_wa !== 5'd5) begin failures++; $display("FAIL alu_rf_wa got=%0d exp=5", rf_wa); end
    checks++; if (rf_wd !== 32'h1234) begin failures++; $display("FAIL alu_rf_wd got=%h exp=00001234", rf_wd); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL alu_instret_pre got=%0d exp=%0d", instret, exp_instret); end
    step(); exp_instret++;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL alu_instret got=%0d exp=%0d", instret, exp_instret); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load_extract();
    issue(5'd3, 1'b1, 2'd1, 32'h103, 32'h0, 3'b000);
    step(); dmem_rdata = 32'h80FF_1122;
    issue(5'd3, 1'b1, 2'd1, 32'h103, 32'h0, 3'b100);
    #1;
    checks++; if (rf_wd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_wd got=%h exp=ffffff80", rf_wd); end
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL lb_we got=%b exp=1", rf_we); end
    step(); exp_instret++;
    issue(5'd4, 1'b1, 2'd1, 32'h102, 32'h0, 3'b001);
    #1;
    checks++; if (rf_wd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_wd got=%h exp=00000080", rf_wd); end
    step(); exp_instret++;
    idle(); #1;
    checks++; if (rf_wd !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_wd got=%h exp=ffff80ff", rf_wd); end
    checks++; if (rf_wa !== 5'd4) begin failures++; $display("FAIL lh_wa got=%0d exp=4", rf_wa); end
    step(); exp_instret++;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_stalled_load();
    issue(5'd7, 1'b1, 2'd1, 32'h200, 32'h0, 3'b010);
    step(); idle();
    dmem_rdata = 32'hCAFE_F00D; stall = 1'b1; #1;
    checks++; if (rf_wd !== 32'hCAFE_F00D) begin failures++; $display("FAIL stall_wd0 got=%h exp=cafef00d", rf_wd); end
    for (int i = 0; i < 3; i++) begin
      step(); dmem_rdata = 32'h0; #1;
      checks++; if (rf_wd !== 32'hCAFE_F00D) begin failures++; $display("FAIL stall_wd%0d got=%h exp=cafef00d", i + 1, rf_wd); end
      checks++; if (rf_we !== 1'b1 || wb_valid !== 1'b1) begin failures++; $display("FAIL stall_we%0d got=%b/%b exp=1/1", i + 1, rf_we, wb_valid); end
      checks++; if (instret !== exp_instret) begin failures++; $display("FAIL stall_instret%0d got=%0d exp=%0d", i + 1, instret, exp_instret); end
    end
    stall = 1'b0; #1;
    checks++; if (rf_wd !== 32'hCAFE_F00D) begin failures++; $display("FAIL stall_release_wd got=%h exp=cafef00d", rf_wd); end
    step(); exp_instret++;
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL stall_release_instret got=%0d exp=%0d", instret, exp_instret); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_x0_bubble();
    issue(5'd0, 1'b1, 2'd0, 32'hDEAD, 32'h0, 3'd0);
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_we got=%b exp=0", rf_we); end
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL x0_valid got=%b exp=1", wb_valid); end
    issue(5'd4, 1'b1, 2'd0, 32'h44, 32'h0, 3'd0);
    flush = 1'b1; stall = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", wb_valid); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", rf_we); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL flush_instret got=%0d exp=%0d", instret, exp_instret); end
    flush = 1'b0; stall = 1'b0; idle();
    step();
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL bubble_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_misalign();
    issue(5'd9, 1'b1, 2'd1, 32'h102, 32'h0, 3'b010);
    step(); dmem_rdata = 32'h1234_5678;
    issue(5'd2, 1'b1, 2'd0, 32'h55, 32'h0, 3'd0);
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mis_we got=%b exp=0", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL mis_fwd got=%b exp=0", fwd_valid); end
    step(); exp_instret++; idle();
    checks++; if (load_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", load_misalign); end
    checks++; if (rf_we !== 1'b1 || rf_wd !== 32'h55) begin failures++; $display("FAIL mis_next_alu got=%b/%h exp=1/00000055", rf_we, rf_wd); end
    step(); exp_instret++;
    checks++; if (load_misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%b exp=1", load_misalign); end
    checks++; if (instret !== exp_instret) begin failures++; $display("FAIL mis_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_pc4_reset();
    issue(5'd1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 3'd0);
    step();
    checks++; if (rf_wd !== 32'h0) begin failures++; $display("FAIL pc4_wd got=%h exp=00000000", rf_wd); end
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd1) begin failures++; $display("FAIL pc4_we got=%b/%0d exp=1/1", rf_we, rf_wa); end
    issue(5'd6, 1'b1, 2'd1, 32'h0, 32'h0, 3'b010);
    step(); exp_instret++; idle();
    dmem_rdata = 32'h11; stall = 1'b1; #1;
    checks++; if (rf_wd !== 32'h11) begin failures++; $display("FAIL rst_pre_wd got=%h exp=00000011", rf_wd); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0; dmem_rdata = 32'hDEAD_BEEF; exp_instret = '0; #1;
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got=%b%b%b exp=000", rf_we, fwd_valid, wb_valid); end
    checks++; if (rf_wa !== 5'd0 || rf_wd !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%0d/%h exp=0/00000000", rf_wa, rf_wd); end
    checks++; if (instret !== exp_instret || load_misalign !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=%0d/%b exp=0/0", instret, load_misalign); end
    step();
    checks++; if (rf_we !== 1'b0 || instret !== exp_instret) begin failures++; $display("FAIL rst_after got=%b/%0d exp=0/0", rf_we, instret); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_stalled_load();
    test_x0_bubble();
    test_misalign();
    test_pc4_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
